// File: rtl/i2c_transaction_sequencer_if.sv
// Request, write-data, read-data and byte-engine signals of the I2C transaction sequencer.
// master = sequencer side, slave = requester/engine side.
interface i2c_transaction_sequencer_if #(
  parameter int LEN_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_read;
  logic [6:0]       req_dev_addr;
  logic [7:0]       req_reg_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       wr_data;
  logic             wr_data_valid;
  logic             wr_data_ready;
  logic [7:0]       rd_data;
  logic             rd_data_valid;
  logic             done;
  logic [2:0]       error;
  logic [2:0]       eng_cmd;
  logic             eng_cmd_valid;
  logic [7:0]       eng_tx_byte;
  logic             eng_done;
  logic             eng_nack;
  logic             eng_timeout;
  logic [7:0]       eng_rx_byte;

  modport master (
    input  req_valid, req_read, req_dev_addr, req_reg_addr, req_len,
    input  wr_data, wr_data_valid,
    input  eng_done, eng_nack, eng_timeout, eng_rx_byte,
    output req_ready, wr_data_ready, rd_data, rd_data_valid, done, error,
    output eng_cmd, eng_cmd_valid, eng_tx_byte
  );

  modport slave (
    output req_valid, req_read, req_dev_addr, req_reg_addr, req_len,
    output wr_data, wr_data_valid,
    output eng_done, eng_nack, eng_timeout, eng_rx_byte,
    input  req_ready, wr_data_ready, rd_data, rd_data_valid, done, error,
    input  eng_cmd, eng_cmd_valid, eng_tx_byte
  );
endinterface

// File: rtl/i2c_transaction_sequencer.sv
// Register-level I2C transaction sequencer: one engine command outstanding, next state the cycle after eng_done.
// Requests accepted only when idle; wr_data is pulled on demand, rd_data is a strobe with no backpressure.
module i2c_transaction_sequencer #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input logic clk,
  input logic reset,
  i2c_transaction_sequencer_if.master bus
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CHECK  = 4'd1;
  localparam logic [3:0] S_START  = 4'd2;
  localparam logic [3:0] S_DEV_W  = 4'd3;
  localparam logic [3:0] S_REG    = 4'd4;
  localparam logic [3:0] S_WFETCH = 4'd5;
  localparam logic [3:0] S_WDATA  = 4'd6;
  localparam logic [3:0] S_RSTART = 4'd7;
  localparam logic [3:0] S_DEV_R  = 4'd8;
  localparam logic [3:0] S_RDATA  = 4'd9;
  localparam logic [3:0] S_STOP   = 4'd10;
  localparam logic [3:0] S_DONE   = 4'd11;

  localparam logic [2:0] C_START  = 3'd0;
  localparam logic [2:0] C_RSTART = 3'd1;
  localparam logic [2:0] C_WRITE  = 3'd2;
  localparam logic [2:0] C_RACK   = 3'd3;
  localparam logic [2:0] C_RNACK  = 3'd4;
  localparam logic [2:0] C_STOP   = 3'd5;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  logic [3:0]       state;
  logic             waiting;
  logic             rd_q;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q;
  logic [7:0]       wdat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [2:0]       err_q;
  logic             rd_vld_q;
  logic [7:0]       rd_dat_q;

  logic cmd_state, step, bad_len, last;

  assign cmd_state = (state == S_START) || (state == S_DEV_W) || (state == S_REG) ||
                     (state == S_WDATA) || (state == S_RSTART) || (state == S_DEV_R) ||
                     (state == S_RDATA) || (state == S_STOP);
  assign step    = waiting && bus.eng_done;
  assign bad_len = len_q > MAX_LEN_L;
  assign last    = (cnt == ONE_L);

  assign bus.req_ready     = (state == S_IDLE);
  assign bus.wr_data_ready = (state == S_WFETCH);
  assign bus.eng_cmd_valid = cmd_state && !waiting;
  assign bus.done          = (state == S_DONE) || (state == S_CHECK && bad_len);
  assign bus.error         = (state == S_CHECK && bad_len) ? 3'd4 : err_q;
  assign bus.rd_data       = rd_dat_q;
  assign bus.rd_data_valid = rd_vld_q;

  always_comb begin
    bus.eng_cmd     = C_START;
    bus.eng_tx_byte = 8'h00;
    case (state)
      S_START:  bus.eng_cmd = C_START;
      S_DEV_W:  begin bus.eng_cmd = C_WRITE; bus.eng_tx_byte = {dev_q, 1'b0}; end
      S_REG:    begin bus.eng_cmd = C_WRITE; bus.eng_tx_byte = reg_q; end
      S_WDATA:  begin bus.eng_cmd = C_WRITE; bus.eng_tx_byte = wdat_q; end
      S_RSTART: bus.eng_cmd = C_RSTART;
      S_DEV_R:  begin bus.eng_cmd = C_WRITE; bus.eng_tx_byte = {dev_q, 1'b1}; end
      S_RDATA:  bus.eng_cmd = last ? C_RNACK : C_RACK;
      S_STOP:   bus.eng_cmd = C_STOP;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      waiting  <= 1'b0;
      rd_q     <= 1'b0;
      dev_q    <= '0;
      reg_q    <= '0;
      wdat_q   <= '0;
      len_q    <= '0;
      cnt      <= '0;
      err_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_vld_q <= 1'b0;
      if (cmd_state && !waiting) waiting <= 1'b1;
      case (state)
        S_IDLE: if (bus.req_valid) begin
          rd_q  <= bus.req_read;
          dev_q <= bus.req_dev_addr;
          reg_q <= bus.req_reg_addr;
          len_q <= bus.req_len;
          cnt   <= bus.req_len;
          err_q <= 3'd0;
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (bad_len) begin
            err_q <= 3'd4;
            state <= S_IDLE;
          end else begin
            state <= S_START;
          end
        end
        S_WFETCH: if (bus.wr_data_valid) begin
          wdat_q <= bus.wr_data;
          state  <= S_WDATA;
        end
        S_DONE: state <= S_IDLE;
        default: if (step) begin
          waiting <= 1'b0;
          // A stretch timeout leaves the bus hung, so no STOP is attempted.
          if (bus.eng_timeout) begin
            err_q <= 3'd3;
            state <= S_DONE;
          end else begin
            case (state)
              S_START: state <= S_DEV_W;
              S_DEV_W: begin
                if (bus.eng_nack) begin err_q <= 3'd1; state <= S_STOP; end
                else state <= S_REG;
              end
              S_REG: begin
                if (bus.eng_nack) begin err_q <= 3'd2; state <= S_STOP; end
                else if (len_q == '0) state <= S_STOP;
                else if (rd_q) state <= S_RSTART;
                else state <= S_WFETCH;
              end
              S_WDATA: begin
                if (bus.eng_nack) begin
                  err_q <= 3'd2;
                  state <= S_STOP;
                end else begin
                  cnt   <= cnt - ONE_L;
                  state <= last ? S_STOP : S_WFETCH;
                end
              end
              S_RSTART: state <= S_DEV_R;
              S_DEV_R: begin
                if (bus.eng_nack) begin err_q <= 3'd1; state <= S_STOP; end
                else state <= S_RDATA;
              end
              S_RDATA: begin
                rd_vld_q <= 1'b1;
                rd_dat_q <= bus.eng_rx_byte;
                cnt      <= cnt - ONE_L;
                state    <= last ? S_STOP : S_RDATA;
              end
              S_STOP:  state <= S_DONE;
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Directed table-driven bench with an in-loop byte-engine responder (3-cycle command latency).
module tb_i2c_transaction_sequencer;
  localparam logic [2:0] C_START = 3'd0, C_RSTART = 3'd1, C_WRITE = 3'd2;
  localparam logic [2:0] C_RACK = 3'd3, C_RNACK = 3'd4, C_STOP = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_transaction_sequencer_if #(.LEN_W(4)) bus ();
  i2c_transaction_sequencer #(.MAX_LEN(8), .LEN_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit         rd;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [3:0] len;
    int         nack_at;
    int         to_at;
    bit         stray;
    logic [2:0] err;
    int         hs;
    int         nrd;
    logic [7:0] wdat [8];
    logic [7:0] rx [8];
    logic [10:0] cmds [12];
    int         nc;
  } tvec_t;

  tvec_t vt [9];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                      input logic [3:0] len, input int nack_at, input int to_at, input bit stray,
                      input logic [2:0] err, input int hs, input int nrd);
    vt[i].rd = rd; vt[i].dev = dev; vt[i].rg = rg; vt[i].len = len;
    vt[i].nack_at = nack_at; vt[i].to_at = to_at; vt[i].stray = stray;
    vt[i].err = err; vt[i].hs = hs; vt[i].nrd = nrd; vt[i].nc = 0;
    for (int k = 0; k < 8; k++) begin vt[i].wdat[k] = 8'hEE; vt[i].rx[k] = 8'h00; end
    for (int k = 0; k < 12; k++) vt[i].cmds[k] = '0;
  endtask

  task automatic addc(input int i, input logic [2:0] c, input logic [7:0] b);
    vt[i].cmds[vt[i].nc] = {c, b};
    vt[i].nc++;
  endtask

  task automatic drive_idle();
    bus.eng_done = 1'b0; bus.eng_nack = 1'b0; bus.eng_timeout = 1'b0; bus.eng_rx_byte = 8'h00;
    bus.wr_data_valid = 1'b0; bus.wr_data = 8'hEE;
  endtask

  // stop_after > 0 abandons the transaction while the DUT waits on that many commands.
  task automatic run(input tvec_t v, input string tag, input int stop_after);
    int ncmd = 0, hs = 0, nrd = 0, nreads = 0, pend = 0;
    bit seen_done = 1'b0, aborted = 1'b0, rn = 1'b0, rt = 1'b0;
    logic [2:0] err = '0;
    logic [7:0] rb = '0;
    logic [10:0] got [12];
    for (int k = 0; k < 12; k++) got[k] = '0;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_read = v.rd; bus.req_dev_addr = v.dev;
    bus.req_reg_addr = v.rg; bus.req_len = v.len;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      drive_idle();
      if (bus.done) begin seen_done = 1'b1; err = bus.error; end
      if (bus.rd_data_valid) begin
        if (nrd < 8) chk($sformatf("%s rd_data%0d", tag, nrd), 32'(bus.rd_data), 32'(v.rx[nrd]));
        nrd++;
      end
      if (bus.eng_cmd_valid) begin
        if (ncmd < 12) got[ncmd] = {bus.eng_cmd, bus.eng_tx_byte};
        rn = (ncmd == v.nack_at);
        rt = (ncmd == v.to_at);
        rb = 8'h00;
        if (bus.eng_cmd == C_RACK || bus.eng_cmd == C_RNACK) begin
          if (nreads < 8) rb = v.rx[nreads];
          nreads++;
        end
        pend = 2;
        ncmd++;
      end else if (pend == 2) begin
        pend = 1;
      end else if (pend == 1) begin
        bus.eng_done = 1'b1; bus.eng_nack = rn; bus.eng_timeout = rt; bus.eng_rx_byte = rb;
        pend = 0;
      end else if (v.stray && !bus.done) begin
        bus.eng_done = 1'b1; bus.eng_nack = 1'b1; bus.eng_timeout = 1'b1;
      end
      if (bus.wr_data_ready) begin
        bus.wr_data_valid = 1'b1;
        bus.wr_data = (hs < 8) ? v.wdat[hs] : 8'hEE;
        hs++;
      end
      if (stop_after > 0 && ncmd == stop_after && pend == 1) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) return;
    chk({tag, " done seen"}, 32'(seen_done), 32'd1);
    chk({tag, " error"}, 32'(err), 32'(v.err));
    chk({tag, " cmd count"}, 32'(ncmd), 32'(v.nc));
    for (int j = 0; j < v.nc && j < 12; j++)
      chk($sformatf("%s cmd%0d", tag, j), 32'(got[j]), 32'(v.cmds[j]));
    chk({tag, " wr handshakes"}, 32'(hs), 32'(v.hs));
    chk({tag, " rd strobes"}, 32'(nrd), 32'(v.nrd));
    @(negedge clk);
    drive_idle();
    chk({tag, " req_ready after done"}, 32'(bus.req_ready), 32'd1);
    chk({tag, " done one cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_dev_addr = '0;
    bus.req_reg_addr = '0; bus.req_len = '0;
    drive_idle();

    // 0: write 0x68/0x00 len 2, stray eng_done pulses while not waiting
    setv(0, 0, 7'h68, 8'h00, 4'd2, -1, -1, 1, 3'd0, 2, 0);
    vt[0].wdat[0] = 8'h12; vt[0].wdat[1] = 8'h34;
    addc(0, C_START, 0); addc(0, C_WRITE, 8'hD0); addc(0, C_WRITE, 8'h00);
    addc(0, C_WRITE, 8'h12); addc(0, C_WRITE, 8'h34); addc(0, C_STOP, 0);
    // 1: read 0x68/0x02 len 3
    setv(1, 1, 7'h68, 8'h02, 4'd3, -1, -1, 0, 3'd0, 0, 3);
    vt[1].rx[0] = 8'h45; vt[1].rx[1] = 8'h23; vt[1].rx[2] = 8'h11;
    addc(1, C_START, 0); addc(1, C_WRITE, 8'hD0); addc(1, C_WRITE, 8'h02);
    addc(1, C_RSTART, 0); addc(1, C_WRITE, 8'hD1); addc(1, C_RACK, 0);
    addc(1, C_RACK, 0); addc(1, C_RNACK, 0); addc(1, C_STOP, 0);
    // 2: write, address NACK
    setv(2, 0, 7'h68, 8'h00, 4'd2, 1, -1, 0, 3'd1, 0, 0);
    vt[2].wdat[0] = 8'h12; vt[2].wdat[1] = 8'h34;
    addc(2, C_START, 0); addc(2, C_WRITE, 8'hD0); addc(2, C_STOP, 0);
    // 3: write, NACK on first data byte
    setv(3, 0, 7'h68, 8'h00, 4'd2, 3, -1, 0, 3'd2, 1, 0);
    vt[3].wdat[0] = 8'h12; vt[3].wdat[1] = 8'h34;
    addc(3, C_START, 0); addc(3, C_WRITE, 8'hD0); addc(3, C_WRITE, 8'h00);
    addc(3, C_WRITE, 8'h12); addc(3, C_STOP, 0);
    // 4: read len 1, timeout on READ_NACK
    setv(4, 1, 7'h68, 8'h02, 4'd1, -1, 5, 0, 3'd3, 0, 0);
    vt[4].rx[0] = 8'h5A;
    addc(4, C_START, 0); addc(4, C_WRITE, 8'hD0); addc(4, C_WRITE, 8'h02);
    addc(4, C_RSTART, 0); addc(4, C_WRITE, 8'hD1); addc(4, C_RNACK, 0);
    // 5: bad length
    setv(5, 0, 7'h68, 8'h00, 4'd9, -1, -1, 0, 3'd4, 0, 0);
    // 6: pointer-only read, len 0
    setv(6, 1, 7'h68, 8'h05, 4'd0, -1, -1, 0, 3'd0, 0, 0);
    addc(6, C_START, 0); addc(6, C_WRITE, 8'hD0); addc(6, C_WRITE, 8'h05); addc(6, C_STOP, 0);
    // 7: read, NACK on read-direction address
    setv(7, 1, 7'h50, 8'h10, 4'd2, 4, -1, 0, 3'd1, 0, 0);
    addc(7, C_START, 0); addc(7, C_WRITE, 8'hA0); addc(7, C_WRITE, 8'h10);
    addc(7, C_RSTART, 0); addc(7, C_WRITE, 8'hA1); addc(7, C_STOP, 0);
    // 8: write of MAX_LEN bytes
    setv(8, 0, 7'h20, 8'h7F, 4'd8, -1, -1, 0, 3'd0, 8, 0);
    addc(8, C_START, 0); addc(8, C_WRITE, 8'h40); addc(8, C_WRITE, 8'h7F);
    for (int k = 0; k < 8; k++) begin
      vt[8].wdat[k] = 8'(k + 1);
      addc(8, C_WRITE, 8'(k + 1));
    end
    addc(8, C_STOP, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset eng_cmd_valid", 32'(bus.eng_cmd_valid), 32'd0);
    chk("reset done/error", 32'({bus.done, bus.error}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run(vt[i], $sformatf("v%0d", i), 0);

    // Reset while waiting on the second READ_ACK, after one byte was delivered.
    run(vt[1], "rst", 7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst strobes", 32'({bus.wr_data_ready, bus.rd_data_valid, bus.done, bus.eng_cmd_valid}), 32'd0);
    chk("rst error", 32'(bus.error), 32'd0);
    chk("rst rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst eng_cmd/tx", 32'({bus.eng_cmd, bus.eng_tx_byte}), 32'd0);
    run(vt[0], "post_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2c_transaction_sequencer.md
Name: i2c_transaction_sequencer

Overview:
Transaction-level controller for the I2C master on the clock board. It accepts one register-oriented request (device address, register pointer, length, direction). It sequences the byte-level I2C engine through START, address, pointer, optional repeated START, data bytes and STOP. It reports data, completion and an error code back to the clock/RTC logic.

Parameters:
MAX_LEN, 8, maximum data bytes per transaction
LEN_W, 4, width of req_len; must hold MAX_LEN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer idle, accepts request
req_read  in  1  1 = register read, 0 = register write
req_dev_addr  in  7  7-bit device address
req_reg_addr  in  8  register pointer
req_len  in  LEN_W  data byte count (0..MAX_LEN)
wr_data  in  8  write data byte
wr_data_valid  in  1  wr_data present
wr_data_ready  out  1  sequencer consumes wr_data this cycle if valid
rd_data  out  8  received byte
rd_data_valid  out  1  one-cycle strobe per received byte
done  out  1  one-cycle strobe, transaction finished
error  out  3  status, valid with done: 0 ok, 1 addr NACK, 2 data/pointer NACK, 3 clock-stretch timeout, 4 bad length
eng_cmd  out  3  0 START, 1 RSTART, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 STOP
eng_cmd_valid  out  1  one-cycle command strobe
eng_tx_byte  out  8  byte for WRITE
eng_done  in  1  one-cycle strobe, command complete
eng_nack  in  1  valid with eng_done after WRITE
eng_timeout  in  1  valid with eng_done, clock-stretch timeout
eng_rx_byte  in  8  valid with eng_done after READ_*

Behaviour:
- Reset: state IDLE; req_ready=1; wr_data_ready, rd_data_valid, done, eng_cmd_valid = 0; error, rd_data, eng_cmd, eng_tx_byte = 0; counters cleared. Reset mid-transaction aborts without issuing STOP. The engine shares the reset.
- Accept on req_valid & req_ready. Inputs are latched. req_ready drops the next cycle.
- Length check in cycle after accept: req_len > MAX_LEN gives done=1, error=4 that cycle, with no engine command.
- Exactly one engine command outstanding. eng_cmd_valid is high for one cycle, then the sequencer waits for eng_done. Commands are never issued while waiting.
- States: IDLE -> START -> DEV_W (tx {dev,0}) -> REG (tx reg_addr) -> branch:
  - write, len>0: WFETCH (wr_data_ready=1 until wr_data_valid, latch, no timeout) -> WDATA (WRITE) -> WFETCH or STOP.
  - read, len>0: RSTART -> DEV_R (tx {dev,1}) -> RDATA; last byte READ_NACK, others READ_ACK.
  - len=0 (either dir): pointer-only write, go to STOP after REG.
  - STOP -> DONE -> IDLE.
- Each command is issued the cycle the state is entered. The next state is entered the cycle after eng_done.
- rd_data_valid strobes the cycle after eng_done of each READ_*, with rd_data = eng_rx_byte. It is not backpressured.
- NACK on DEV_W/DEV_R: STOP, then error=1. NACK on REG/WDATA: STOP, then error=2. Remaining bytes are skipped; no further wr_data_ready.
- eng_timeout on any eng_done: go directly to DONE with error=3, no STOP (bus assumed hung). Timeout takes priority over NACK when both are set.
- DONE: done=1 for one cycle with final error. req_ready=1 the next cycle. A new request may be accepted that cycle.
- Byte counter counts down from len. Counter width LEN_W with no wrap, since len=0 bypasses data states.
- eng_done while not waiting is ignored.

Test Plan:
- Write dev 0x68, reg 0x00, len 2, data 0x12,0x34, engine always ACK -> eng_cmd sequence START, WRITE 0xD0, WRITE 0x00, WRITE 0x12, WRITE 0x34, STOP; done with error=0; exactly 2 wr_data_ready handshakes.
- Read dev 0x68, reg 0x02, len 3, engine returns 0x45,0x23,0x11 -> START, WRITE 0xD0, WRITE 0x02, RSTART, WRITE 0xD1, READ_ACK, READ_ACK, READ_NACK, STOP; three rd_data_valid strobes with those values; error=0.
- Write len 2, engine NACKs WRITE 0xD0 -> STOP next, no wr_data_ready ever, done with error=1; repeat with NACK on first data byte -> error=2, second byte never fetched.
- Read len 1 with eng_timeout on READ_NACK -> no STOP issued, done with error=3, req_ready=1 the following cycle.
- req_len=9 (MAX_LEN=8) -> zero eng_cmd_valid, done with error=4. req_len=0 read -> START, 0xD0, reg, STOP, error=0, no rd_data_valid.
- Assert reset while waiting in RDATA -> next cycle all outputs at reset values, req_ready=1. A new write request then completes normally.
